// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and sizing helper for the multicycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_LSL   = 4'b0011;
    localparam logic [3:0] OP_LSR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_UDIV  = 4'b1001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: shift-add multiply or restoring divide, one bit per edge.
// The first step is taken on the start edge, so WIDTH steps finish WIDTH-1 edges later.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0]    cnt;
    logic             busy;
    logic             div_q;
    // x: accumulator / remainder, y: multiplicand / dividend-quotient, z: multiplier / divisor
    logic [WIDTH-1:0] x, y, z;
    logic [WIDTH-1:0] src_x, src_y, src_z;
    logic [WIDTH-1:0] nx, ny, nz;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   r_sh;
    logic             mode;
    logic             ge;

    always_comb begin
        src_x = start ? '0 : x;
        src_y = start ? a : y;
        src_z = start ? b : z;
        mode  = start ? is_div : div_q;
        r_sh  = {src_x, src_y[WIDTH-1]};
        ge    = (r_sh >= {1'b0, src_z});
        diff  = r_sh[WIDTH-1:0] - src_z;
        if (mode) begin
            nx = ge ? diff : r_sh[WIDTH-1:0];
            ny = {src_y[WIDTH-2:0], ge};
            nz = src_z;
        end else begin
            nx = src_x + (src_z[0] ? src_y : '0);
            ny = src_y << 1;
            nz = src_z >> 1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            busy  <= 1'b0;
            cnt   <= '0;
            div_q <= 1'b0;
            x     <= '0;
            y     <= '0;
            z     <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= CW'(WIDTH - 1);
            div_q <= is_div;
            x     <= nx;
            y     <= ny;
            z     <= nz;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) busy <= 1'b0;
            x <= nx;
            y <= ny;
            z <= nz;
        end
    end

    assign done        = busy && (cnt == CW'(1));
    assign result      = div_q ? ny : nx;
    assign div_by_zero = div_q && (z == '0);

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/arith/shift ops plus iterative MUL/UDIV,
// valid/ready on both sides, registered result and NZCV/DivByZero flags.
//   state | meaning
//   IDLE  | ready for a request
//   BUSY  | iterative MUL/UDIV in progress
//   DONE  | result valid, waiting for OutReady
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter bit MUL_EN = 1'b1,
    parameter bit DIV_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic [3:0]       ALUCtrl,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] BusW,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow,
    output logic             DivByZero
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state, state_nx;
    logic             accept, op_mul, op_div, iter_op;
    logic [WIDTH-1:0] sc_w;
    logic             sc_c, sc_v;
    logic [WIDTH:0]   sum, dif;
    logic [SHW-1:0]   shamt;
    logic             eng_done, eng_dbz;
    logic [WIDTH-1:0] eng_result;

    assign InReady  = (state == IDLE);
    assign OutValid = (state == DONE);
    assign accept   = InValid && InReady;
    assign op_mul   = (ALUCtrl == OP_MUL) && MUL_EN;
    assign op_div   = (ALUCtrl == OP_UDIV) && DIV_EN;
    assign iter_op  = op_mul || op_div;

    always_comb begin
        sum   = {1'b0, BusA} + {1'b0, BusB};
        dif   = {1'b0, BusA} - {1'b0, BusB};
        shamt = BusB[SHW-1:0];
        sc_w  = '0;
        sc_c  = 1'b0;
        sc_v  = 1'b0;
        case (ALUCtrl)
            OP_AND:   sc_w = BusA & BusB;
            OP_OR:    sc_w = BusA | BusB;
            OP_ADD: begin
                sc_w = sum[WIDTH-1:0];
                sc_c = sum[WIDTH];
                sc_v = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (sum[WIDTH-1] != BusA[WIDTH-1]);
            end
            OP_SUB: begin
                sc_w = dif[WIDTH-1:0];
                sc_c = ~dif[WIDTH];
                sc_v = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (dif[WIDTH-1] != BusA[WIDTH-1]);
            end
            OP_LSL:   sc_w = BusA << shamt;
            OP_LSR:   sc_w = BusA >> shamt;
            OP_PASSB: sc_w = BusB;
            default:  sc_w = '0;
        endcase
    end

    generate
        if (MUL_EN || DIV_EN) begin : g_iter
            alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
                .CLK         (CLK),
                .Reset       (Reset),
                .start       (accept && iter_op),
                .is_div      (op_div),
                .a           (BusA),
                .b           (BusB),
                .done        (eng_done),
                .result      (eng_result),
                .div_by_zero (eng_dbz)
            );
        end else begin : g_no_iter
            assign eng_done   = 1'b0;
            assign eng_result = '0;
            assign eng_dbz    = 1'b0;
        end
    endgenerate

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = iter_op ? BUSY : DONE;
            BUSY:    if (eng_done) state_nx = DONE;
            DONE:    if (OutReady) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            BusW      <= '0;
            Zero      <= 1'b0;
            Negative  <= 1'b0;
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            DivByZero <= 1'b0;
        end else if (accept && !iter_op) begin
            BusW      <= sc_w;
            Zero      <= (sc_w == '0);
            Negative  <= sc_w[WIDTH-1];
            Carry     <= sc_c;
            Overflow  <= sc_v;
            DivByZero <= 1'b0;
        end else if (state == BUSY && eng_done) begin
            BusW      <= eng_result;
            Zero      <= (eng_result == '0);
            Negative  <= eng_result[WIDTH-1];
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            DivByZero <= eng_dbz;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at WIDTH=64 and WIDTH=8.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        Reset;
    logic        iv0, ir0, ov0, or0, z0, n0, c0, v0, d0;
    logic [63:0] a0, b0, w0;
    logic [3:0]  op0;
    logic        iv1, ir1, ov1, or1, z1, n1, c1, v1, d1;
    logic [7:0]  a1, b1, w1;
    logic [3:0]  op1;

    alu_multicycle #(.WIDTH(64)) dut64 (
        .CLK(CLK), .Reset(Reset), .InValid(iv0), .InReady(ir0), .BusA(a0), .BusB(b0),
        .ALUCtrl(op0), .OutValid(ov0), .OutReady(or0), .BusW(w0), .Zero(z0),
        .Negative(n0), .Carry(c0), .Overflow(v0), .DivByZero(d0));

    alu_multicycle #(.WIDTH(8)) dut8 (
        .CLK(CLK), .Reset(Reset), .InValid(iv1), .InReady(ir1), .BusA(a1), .BusB(b1),
        .ALUCtrl(op1), .OutValid(ov1), .OutReady(or1), .BusW(w1), .Zero(z1),
        .Negative(n1), .Carry(c1), .Overflow(v1), .DivByZero(d1));

    typedef struct {
        logic [63:0] w;
        logic [4:0]  fl;   // {Z,N,C,V,DivByZero}
        int          lat;
        int          acc;
    } exp_t;

    exp_t q0[$], q1[$];
    exp_t e0, e1;
    int checks = 0, failures = 0, cyc = 0;
    int done0 = 0, done1 = 0, rise0 = 0, rise1 = 0;
    bit seen0 = 0, seen1 = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!Reset && ov0) begin
            if (!seen0) begin rise0 = cyc; seen0 = 1; end
            if (or0) begin
                seen0 = 0;
                if (q0.size() == 0) chk("w64_unexpected_output", 64'd1, 64'd0);
                else begin
                    e0 = q0.pop_front();
                    chk("w64_busw", w0, e0.w);
                    chk("w64_flags", {59'b0, z0, n0, c0, v0, d0}, {59'b0, e0.fl});
                    chk("w64_latency", 64'(rise0 - e0.acc + 1), 64'(e0.lat));
                    done0++;
                end
            end
        end else seen0 = 0;
    end

    always @(negedge CLK) begin
        if (!Reset && ov1) begin
            if (!seen1) begin rise1 = cyc; seen1 = 1; end
            if (or1) begin
                seen1 = 0;
                if (q1.size() == 0) chk("w8_unexpected_output", 64'd1, 64'd0);
                else begin
                    e1 = q1.pop_front();
                    chk("w8_busw", {56'b0, w1}, e1.w);
                    chk("w8_flags", {59'b0, z1, n1, c1, v1, d1}, {59'b0, e1.fl});
                    chk("w8_latency", 64'(rise1 - e1.acc + 1), 64'(e1.lat));
                    done1++;
                end
            end
        end else seen1 = 0;
    end

    function automatic logic get_ir(input int inst);
        return (inst == 0) ? ir0 : ir1;
    endfunction
    function automatic logic get_ov(input int inst);
        return (inst == 0) ? ov0 : ov1;
    endfunction
    function automatic int get_done(input int inst);
        return (inst == 0) ? done0 : done1;
    endfunction

    task automatic set_or(input int inst, input logic v);
        if (inst == 0) or0 = v; else or1 = v;
    endtask

    // Inputs change at posedge+1; the DUT samples at the next posedge.
    task automatic issue(input int inst, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] ew, input logic [4:0] efl,
                         input int lat, input int hold);
        int t;
        int d_before;
        exp_t e;
        t = 0;
        while (!get_ir(inst) && t < 200) begin @(posedge CLK); #1; t++; end
        if (t >= 200) begin chk("ready_timeout", 64'd1, 64'd0); return; end
        d_before = get_done(inst);
        e.w = ew; e.fl = efl; e.lat = lat; e.acc = cyc + 1;
        if (inst == 0) begin
            q0.push_back(e);
            a0 = a; b0 = b; op0 = op; iv0 = 1'b1;
        end else begin
            q1.push_back(e);
            a1 = a[7:0]; b1 = b[7:0]; op1 = op; iv1 = 1'b1;
        end
        set_or(inst, hold == 0);
        @(posedge CLK); #1;
        // scramble operands after the accept edge; the result must not follow them
        if (inst == 0) begin
            iv0 = 1'b0; a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom}; op0 = OP_PASSB;
        end else begin
            iv1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom); op1 = OP_PASSB;
        end
        if (hold > 0) begin
            t = 0;
            while (!get_ov(inst) && t < 200) begin @(posedge CLK); #1; t++; end
            if (t >= 200) chk("valid_timeout", 64'd1, 64'd0);
            for (int k = 0; k < hold; k++) begin
                chk("hold_outvalid", {63'b0, get_ov(inst)}, 64'd1);
                chk("hold_inready", {63'b0, get_ir(inst)}, 64'd0);
                @(posedge CLK); #1;
            end
            set_or(inst, 1'b1);
        end
        t = 0;
        while (get_done(inst) == d_before && t < 200) begin @(posedge CLK); #1; t++; end
        if (t >= 200) begin chk("result_timeout", 64'd1, 64'd0); return; end
        chk("inready_after_handshake", {63'b0, get_ir(inst)}, 64'd1);
        chk("outvalid_after_handshake", {63'b0, get_ov(inst)}, 64'd0);
    endtask

    initial begin
        Reset = 1'b1;
        iv0 = 0; a0 = '0; b0 = '0; op0 = '0; or0 = 1'b1;
        iv1 = 0; a1 = '0; b1 = '0; op1 = '0; or1 = 1'b1;
        repeat (3) @(posedge CLK);
        #1 Reset = 1'b0;

        chk("reset_inready", {63'b0, ir0}, 64'd1);
        chk("reset_outvalid", {63'b0, ov0}, 64'd0);
        chk("reset_busw", w0, 64'd0);
        chk("reset_flags", {59'b0, z0, n0, c0, v0, d0}, 64'd0);

        issue(0, OP_ADD,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 5'b10100, 1, 0);
        issue(0, OP_SUB,   64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 5'b00110, 1, 0);
        issue(0, OP_ADD,   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 5'b01010, 1, 0);
        issue(0, OP_SUB,   64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 5'b01000, 1, 0);
        issue(0, OP_AND,   64'hF0F0, 64'h0FF0, 64'h00F0, 5'b00000, 1, 0);
        issue(0, OP_OR,    64'hF000, 64'h000F, 64'hF00F, 5'b00000, 1, 0);
        issue(0, OP_PASSB, 64'd7, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 5'b01000, 1, 0);
        issue(0, OP_LSL,   64'd1, 64'h43, 64'd8, 5'b00000, 1, 0);
        issue(0, OP_LSR,   64'h8000_0000_0000_0000, 64'h7F, 64'd1, 5'b00000, 1, 0);
        issue(0, 4'b1111,  64'd5, 64'd7, 64'd0, 5'b10000, 1, 0);
        issue(0, OP_MUL,   64'd12345, 64'd678, 64'd8369910, 5'b00000, 64, 5);
        issue(0, OP_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 5'b01000, 64, 0);
        issue(0, OP_UDIV,  64'd100, 64'd7, 64'd14, 5'b00000, 64, 0);

        issue(1, OP_UDIV,  64'd200, 64'd7, 64'd28, 5'b00000, 8, 0);
        issue(1, OP_UDIV,  64'd5, 64'd0, 64'hFF, 5'b01001, 8, 0);
        issue(1, OP_MUL,   64'd15, 64'd17, 64'hFF, 5'b01000, 8, 2);
        issue(1, OP_UDIV,  64'd255, 64'd255, 64'd1, 5'b00000, 8, 0);
        issue(1, OP_ADD,   64'h7F, 64'h01, 64'h80, 5'b01010, 1, 0);
        issue(1, OP_SUB,   64'd3, 64'd3, 64'd0, 5'b10100, 1, 0);

        // Reset ten cycles into a MUL: no result may ever appear for it
        a0 = 64'd12345; b0 = 64'd678; op0 = OP_MUL; iv0 = 1'b1; or0 = 1'b1;
        @(posedge CLK); #1 iv0 = 1'b0;
        chk("mul_busy_inready", {63'b0, ir0}, 64'd0);
        repeat (9) begin @(posedge CLK); #1; end
        Reset = 1'b1;
        @(posedge CLK); #1 Reset = 1'b0;
        chk("abort_inready", {63'b0, ir0}, 64'd1);
        chk("abort_outvalid", {63'b0, ov0}, 64'd0);
        chk("abort_busw", w0, 64'd0);
        chk("abort_flags", {59'b0, z0, n0, c0, v0, d0}, 64'd0);
        issue(0, OP_ADD, 64'd2, 64'd3, 64'd5, 5'b00000, 1, 0);
        repeat (70) begin @(posedge CLK); #1; end
        chk("final_outvalid", {63'b0, ov0}, 64'd0);
        chk("scoreboard_empty", 64'(q0.size() + q1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
